// File: rtl/bht_update_queue.sv
// Queue of in-flight predicted branches. Fetch pushes branches, execute
// resolves them in order, and the drain FSM writes each resolved outcome
// into the BHT write port. The write takes two cycles: SETUP gives the BHT
// one cycle to allocate the tag, then COMMIT asserts the write enable.
//
// state  | meaning
// IDLE   | no resolved entry waiting to be written
// SETUP  | bht_* index/tag loaded, write enable low (tag allocation cycle)
// COMMIT | write enable high for one cycle; retire the entry at rd_ptr
module bht_update_queue #(
    parameter int INDEX_LEN = 7,
    parameter int TAG_LEN   = 7,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [INDEX_LEN-1:0]       pred_index,
    input  logic [TAG_LEN-1:0]         pred_tag,
    input  logic [1:0]                 pred_count,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    input  logic                       flush,
    output logic                       mispredict,
    output logic [INDEX_LEN-1:0]       bht_index_write,
    output logic [TAG_LEN-1:0]         bht_tag_write,
    output logic                       bht_increment_decrement,
    output logic                       bht_write_enabled,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Pointers carry one extra wrap bit so that full and empty differ.
    logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        res_ptr_q, res_ptr_d;
    logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        occupancy_q, occupancy_d;

    logic [INDEX_LEN-1:0] idx_mem_q [DEPTH];
    logic [INDEX_LEN-1:0] idx_mem_d [DEPTH];
    logic [TAG_LEN-1:0]   tag_mem_q [DEPTH];
    logic [TAG_LEN-1:0]   tag_mem_d [DEPTH];
    logic [DEPTH-1:0]     pt_mem_q, pt_mem_d;
    logic [DEPTH-1:0]     out_mem_q, out_mem_d;

    state_t               state_q, state_d;
    logic [INDEX_LEN-1:0] bht_index_q, bht_index_d;
    logic [TAG_LEN-1:0]   bht_tag_q, bht_tag_d;
    logic                 bht_inc_q, bht_inc_d;
    logic                 bht_we_q, bht_we_d;
    logic                 mispredict_q, mispredict_d;

    logic [PW-1:0]        wr_idx, res_idx, rd_idx, rd_next_idx;
    logic [CW-1:0]        unres_cnt, resolved_cnt;
    logic                 push, resolve, commit;

    assign wr_idx       = wr_ptr_q[PW-1:0];
    assign res_idx      = res_ptr_q[PW-1:0];
    assign rd_idx       = rd_ptr_q[PW-1:0];
    assign rd_next_idx  = rd_idx + PW'(1);
    assign unres_cnt    = wr_ptr_q - res_ptr_q;
    assign resolved_cnt = res_ptr_q - rd_ptr_q;

    // Full is judged on the registered count only, so a same-cycle commit
    // never makes room for a push.
    assign pred_ready = (occupancy_q < DEPTH_C);
    assign res_ready  = (unres_cnt != '0);
    assign push       = pred_valid & pred_ready & ~flush;
    assign resolve    = res_valid & res_ready;

    assign mispredict              = mispredict_q;
    assign bht_index_write         = bht_index_q;
    assign bht_tag_write           = bht_tag_q;
    assign bht_increment_decrement = bht_inc_q;
    assign bht_write_enabled       = bht_we_q;
    assign occupancy               = occupancy_q;

    // Entry storage: branch info on push, outcome on resolution.
    always_comb begin
        idx_mem_d = idx_mem_q;
        tag_mem_d = tag_mem_q;
        pt_mem_d  = pt_mem_q;
        out_mem_d = out_mem_q;
        if (push) begin
            idx_mem_d[wr_idx] = pred_index;
            tag_mem_d[wr_idx] = pred_tag;
            pt_mem_d[wr_idx]  = pred_count[1];
        end
        if (resolve) begin
            out_mem_d[res_idx] = res_taken;
        end
    end

    // Drain FSM: load entry, one quiet SETUP cycle, one COMMIT write cycle.
    always_comb begin
        state_d     = state_q;
        bht_index_d = bht_index_q;
        bht_tag_d   = bht_tag_q;
        bht_inc_d   = bht_inc_q;
        bht_we_d    = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (resolved_cnt != '0) begin
                    bht_index_d = idx_mem_q[rd_idx];
                    bht_tag_d   = tag_mem_q[rd_idx];
                    bht_inc_d   = out_mem_q[rd_idx];
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                bht_we_d = 1'b1;
                state_d  = COMMIT;
            end
            COMMIT: begin
                commit = 1'b1;
                if (resolved_cnt > ONE_C) begin
                    bht_index_d = idx_mem_q[rd_next_idx];
                    bht_tag_d   = tag_mem_q[rd_next_idx];
                    bht_inc_d   = out_mem_q[rd_next_idx];
                    state_d     = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer and occupancy bookkeeping; flush rewinds wr_ptr to the
    // post-resolution res_ptr so a resolving entry survives the flush.
    always_comb begin
        res_ptr_d = resolve ? res_ptr_q + ONE_C : res_ptr_q;
        rd_ptr_d  = commit ? rd_ptr_q + ONE_C : rd_ptr_q;
        if (flush) begin
            wr_ptr_d = res_ptr_d;
        end else if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        occupancy_d  = wr_ptr_d - rd_ptr_d;
        mispredict_d = resolve & (pt_mem_q[res_idx] != res_taken);
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            res_ptr_q    <= '0;
            rd_ptr_q     <= '0;
            occupancy_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
            end
            pt_mem_q     <= '0;
            out_mem_q    <= '0;
            state_q      <= IDLE;
            bht_index_q  <= '0;
            bht_tag_q    <= '0;
            bht_inc_q    <= 1'b0;
            bht_we_q     <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            res_ptr_q    <= res_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occupancy_q  <= occupancy_d;
            idx_mem_q    <= idx_mem_d;
            tag_mem_q    <= tag_mem_d;
            pt_mem_q     <= pt_mem_d;
            out_mem_q    <= out_mem_d;
            state_q      <= state_d;
            bht_index_q  <= bht_index_d;
            bht_tag_q    <= bht_tag_d;
            bht_inc_q    <= bht_inc_d;
            bht_we_q     <= bht_we_d;
            mispredict_q <= mispredict_d;
        end
    end

endmodule
